// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns the EX/MEM access into a req/gnt/rvalid data-memory
// transaction, stalls the pipeline while it is in flight and returns extended load data.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   input  logic        mem_load,
   input  logic        mem_store,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        lsu_stall,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err,
   output logic [1:0]  lsu_err_cause
);
   localparam int unsigned   CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
   state_e state_q, state_d;

   logic          access, f3_legal, misal, chk_err, timeout;
   logic [1:0]    chk_cause;
   logic [3:0]    be_new;
   logic [31:0]   wdata_new, load_ext;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          store_q, store_d, err_q, err_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d, cause_q, cause_d;
   logic          req_q, req_d, we_q, we_d;
   logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]    be_q, be_d;

   // Decode of the access currently presented by EX/MEM.
   always_comb begin
      access = mem_valid & (mem_load | mem_store);
      case (mem_funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = ~mem_store;
         default:                f3_legal = 1'b0;
      endcase
      misal     = ((mem_funct3[1:0] == 2'b01) & mem_addr[0]) |
                  ((mem_funct3[1:0] == 2'b10) & (|mem_addr[1:0]));
      chk_err   = (mem_load & mem_store) | ~f3_legal | misal;
      chk_cause = ((mem_load & mem_store) | ~f3_legal) ? 2'b00 :
                  (mem_load ? 2'b01 : 2'b10);
      case (mem_funct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << mem_addr[1:0];
            wdata_new = {4{mem_wdata[7:0]}};
         end
         2'b01: begin
            be_new    = 4'b0011 << {mem_addr[1], 1'b0};
            wdata_new = {2{mem_wdata[15:0]}};
         end
         default: begin
            be_new    = 4'b1111;
            wdata_new = mem_wdata;
         end
      endcase
   end

   // Lane selection and extension of the returned word.
   always_comb begin
      ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
      ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  load_ext = {24'b0, ld_byte};
         3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  load_ext = {16'b0, ld_half};
         default: load_ext = dmem_rdata;
      endcase
   end

   assign timeout = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (access) state_d = chk_err ? S_DONE : S_REQ;
         S_REQ: begin
            if (dmem_gnt)     state_d = (store_q | dmem_rvalid) ? S_DONE : S_WAIT;
            else if (timeout) state_d = S_DONE;
         end
         S_WAIT:  if (dmem_rvalid | timeout) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Stall is gated by reset so every output reads 0 while rst_n is low.
   always_comb begin
      lsu_stall = rst_n & (((state_q == S_IDLE) & access) |
                           (state_q == S_REQ) | (state_q == S_WAIT));
      lsu_done  = (state_q == S_DONE);
      lsu_err   = (state_q == S_DONE) & err_q;
   end

   always_comb begin
      cnt_d   = cnt_q;
      store_d = store_q;
      f3_d    = f3_q;
      off_d   = off_q;
      err_d   = err_q;
      cause_d = cause_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (access && chk_err) begin
               err_d   = 1'b1;
               cause_d = chk_cause;
            end else if (access) begin
               err_d   = 1'b0;
               cnt_d   = '0;
               store_d = mem_store;
               f3_d    = mem_funct3;
               off_d   = mem_addr[1:0];
               req_d   = 1'b1;
               we_d    = mem_store;
               addr_d  = {mem_addr[31:2], 2'b00};
               be_d    = be_new;
               wdata_d = wdata_new;
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (dmem_gnt) begin
               req_d = 1'b0;
               if (!store_q && dmem_rvalid) rdata_d = load_ext;
            end else if (timeout) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               cause_d = 2'b11;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (dmem_rvalid) begin
               rdata_d = load_ext;
            end else if (timeout) begin
               err_d   = 1'b1;
               cause_d = 2'b11;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         store_q <= 1'b0;
         f3_q    <= 3'b0;
         off_q   <= 2'b0;
         err_q   <= 1'b0;
         cause_q <= 2'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'b0;
         be_q    <= 4'b0;
         wdata_q <= 32'b0;
         rdata_q <= 32'b0;
      end else begin
         cnt_q   <= cnt_d;
         store_q <= store_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         err_q   <= err_d;
         cause_q <= cause_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign dmem_req      = req_q;
   assign dmem_we       = we_q;
   assign dmem_addr     = addr_q;
   assign dmem_be       = be_q;
   assign dmem_wdata    = wdata_q;
   assign lsu_rdata     = rdata_q;
   assign lsu_err_cause = cause_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a small memory responder drives gnt/rvalid with chosen delays and
// each scenario compares the observed transaction against an arithmetic model of the LSU rules.
module tb_mem_stage_lsu;
   localparam int TO = 8;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        mem_valid = 1'b0, mem_load = 1'b0, mem_store = 1'b0;
   logic [2:0]  mem_funct3 = 3'b0;
   logic [31:0] mem_addr = 32'b0, mem_wdata = 32'b0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'b0;
   logic        lsu_stall, lsu_done, lsu_err;
   logic [31:0] lsu_rdata;
   logic [1:0]  lsu_err_cause;

   always #5 clk = ~clk;

   mem_stage_lsu #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_load(mem_load), .mem_store(mem_store),
      .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
      .lsu_rdata(lsu_rdata), .lsu_err(lsu_err), .lsu_err_cause(lsu_err_cause)
   );

   int n_pass = 0, n_total = 0;
   logic [31:0] exp_rd = 32'b0;

   // Observations of the most recent access.
   int          o_done_cyc, o_stall_cnt, o_req_cnt;
   bit          o_req_seen, o_unstable, o_err;
   logic [1:0]  o_cause;
   logic [31:0] o_rdata, o_addr, o_wdata;
   logic [3:0]  o_be;
   logic        o_we;

   function automatic int m_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   // -1 = legal access, otherwise the expected error cause.
   function automatic int m_cause(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] a);
      bit legal;
      legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
      if ((ld && st) || !legal) return 0;
      if (int'(a % 32'(m_size(f3))) != 0) return ld ? 1 : 2;
      return -1;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int mask;
      mask = (1 << m_size(f3)) - 1;
      return 4'(mask << int'(a % 32'd4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
      if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
      int sz, sh;
      logic [31:0] v;
      sz = m_size(f3);
      if (sz == 4) return rd;
      sh = 8 * int'(a % 32'd4);
      v = (rd >> sh) & ((32'd1 << (8 * sz)) - 32'd1);
      if (!f3[2] && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
      return v;
   endfunction

   // Cycle (counted from presentation = 0) in which lsu_done is expected.
   function automatic int m_done_cyc(input bit ld, input int cause, input int gdly, input int rdly);
      int r;
      if (cause >= 0) return 1;
      if (gdly >= TO) return TO + 1;
      if (!ld) return gdly + 2;
      r = 1 + gdly + rdly;
      return (r <= TO) ? r + 1 : TO + 1;
   endfunction

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         mem_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
         dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      end
   endtask

   // Presents one access and plays memory: gnt after gdly request cycles, rvalid rdly cycles later.
   task automatic run_access(input bit ld, input bit st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int gdly, input int rdly);
      int reqcnt, gcyc;
      bit gseen;
      o_done_cyc = -1; o_stall_cnt = 0; o_req_cnt = 0; o_req_seen = 0; o_unstable = 0;
      o_err = 0; o_cause = 2'b0; o_rdata = 32'b0;
      reqcnt = 0; gcyc = 0; gseen = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 0) begin
            mem_valid = 1'b1; mem_load = ld; mem_store = st;
            mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
         end
         dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
         if (dmem_req) begin
            if (reqcnt == gdly) begin
               dmem_gnt = 1'b1; gseen = 1; gcyc = cyc;
            end
            reqcnt++;
         end
         if (gseen && ld && cyc == gcyc + rdly) begin
            dmem_rvalid = 1'b1; dmem_rdata = rd;
         end
         @(negedge clk);
         if (lsu_stall) o_stall_cnt++;
         if (dmem_req) begin
            if (!o_req_seen) begin
               o_we = dmem_we; o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata;
            end else if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {o_we, o_addr, o_be, o_wdata}) begin
               o_unstable = 1;
            end
            o_req_seen = 1; o_req_cnt++;
         end
         if (lsu_done) begin
            o_done_cyc = cyc; o_err = lsu_err; o_cause = lsu_err_cause; o_rdata = lsu_rdata;
            break;
         end
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      $display("txn ld=%0d st=%0d f3=%0d addr=%h wd=%h done_cyc=%0d err=%0d cause=%0d rdata=%h",
               ld, st, f3, a, wd, o_done_cyc, o_err, o_cause, o_rdata);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== 70'b0)
         $display("FAIL reset_dmem: got %h want 0", {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata});
      else n_pass++;
      n_total++;
      if ({lsu_stall, lsu_done, lsu_err, lsu_err_cause, lsu_rdata} !== 37'b0)
         $display("FAIL reset_lsu: got %h want 0", {lsu_stall, lsu_done, lsu_err, lsu_err_cause, lsu_rdata});
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_rd = 32'b0;
   endtask

   task automatic test_lw_basic();
      run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1);
      n_total++;
      if (o_done_cyc !== 3) $display("FAIL lw_done_cyc: got %0d want 3", o_done_cyc); else n_pass++;
      n_total++;
      if (o_stall_cnt !== 3) $display("FAIL lw_stall_cycles: got %0d want 3", o_stall_cnt); else n_pass++;
      n_total++;
      if ({o_we, o_addr, o_be} !== {1'b0, 32'h100, 4'b1111})
         $display("FAIL lw_req: got we=%0b addr=%h be=%b want we=0 addr=00000100 be=1111", o_we, o_addr, o_be);
      else n_pass++;
      n_total++;
      if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0)
         $display("FAIL lw_rdata: got %h err=%0b want deadbeef err=0", o_rdata, o_err);
      else n_pass++;
      exp_rd = 32'hDEAD_BEEF;
      idle_cycles(1);
      @(negedge clk);
      n_total++;
      if (lsu_done !== 1'b0 || lsu_rdata !== exp_rd)
         $display("FAIL lw_after_done: got done=%0b rdata=%h want done=0 rdata=%h", lsu_done, lsu_rdata, exp_rd);
      else n_pass++;
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3s[3] = '{3'b000, 3'b100, 3'b101};
      logic [31:0] as[3]  = '{32'h103, 32'h103, 32'h102};
      logic [31:0] ws[3]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
      logic [2:0]  lf[5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      logic [2:0]  f3;
      logic [31:0] a, rd;
      int gd, rdl, sz;
      for (int i = 0; i < 3; i++) begin
         run_access(1, 0, f3s[i], as[i], 32'h0, 32'h80FF_0000, 0, 1);
         exp_rd = ws[i];
         n_total++;
         if (o_rdata !== exp_rd) $display("FAIL load_ext_vec%0d: got %h want %h", i, o_rdata, exp_rd);
         else n_pass++;
      end
      for (int i = 0; i < 15; i++) begin
         f3 = lf[$urandom_range(0, 4)];
         sz = m_size(f3);
         a  = ($urandom & 32'hFFFF_FFFC) + 32'($urandom_range(0, 3) / sz * sz);
         rd = $urandom; gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
         run_access(1, 0, f3, a, 32'h0, rd, gd, rdl);
         exp_rd = m_load(f3, a, rd);
         n_total++;
         if (o_done_cyc !== m_done_cyc(1, -1, gd, rdl) || o_err !== 1'b0)
            $display("FAIL load_timing: got cyc=%0d err=%0b want cyc=%0d err=0", o_done_cyc, o_err, m_done_cyc(1, -1, gd, rdl));
         else n_pass++;
         n_total++;
         if (o_rdata !== exp_rd || o_be !== m_be(f3, a) || o_addr !== (a & 32'hFFFF_FFFC))
            $display("FAIL load_data: got rdata=%h be=%b addr=%h want rdata=%h be=%b addr=%h",
                     o_rdata, o_be, o_addr, exp_rd, m_be(f3, a), a & 32'hFFFF_FFFC);
         else n_pass++;
      end
   endtask

   task automatic test_store();
      logic [2:0]  f3;
      logic [31:0] a, wd;
      int gd, sz;
      run_access(0, 1, 3'b000, 32'h201, 32'h1234_5678, 32'h0, 0, 0);
      n_total++;
      if ({o_we, o_be, o_wdata, o_addr} !== {1'b1, 4'b0010, 32'h7878_7878, 32'h200})
         $display("FAIL sb_req: got we=%0b be=%b wdata=%h addr=%h want we=1 be=0010 wdata=78787878 addr=00000200",
                  o_we, o_be, o_wdata, o_addr);
      else n_pass++;
      n_total++;
      if (o_done_cyc !== 2 || o_rdata !== exp_rd || o_err !== 1'b0)
         $display("FAIL sb_done: got cyc=%0d rdata=%h err=%0b want cyc=2 rdata=%h err=0", o_done_cyc, o_rdata, o_err, exp_rd);
      else n_pass++;
      for (int i = 0; i < 12; i++) begin
         f3 = 3'($urandom_range(0, 2));
         sz = m_size(f3);
         a  = ($urandom & 32'hFFFF_FFFC) + 32'($urandom_range(0, 3) / sz * sz);
         wd = $urandom; gd = $urandom_range(0, 4);
         run_access(0, 1, f3, a, wd, 32'h0, gd, 0);
         n_total++;
         if ({o_we, o_be, o_wdata} !== {1'b1, m_be(f3, a), m_wdata(f3, wd)} || o_unstable)
            $display("FAIL store_lanes: got we=%0b be=%b wdata=%h unstable=%0b want we=1 be=%b wdata=%h unstable=0",
                     o_we, o_be, o_wdata, o_unstable, m_be(f3, a), m_wdata(f3, wd));
         else n_pass++;
         n_total++;
         if (o_done_cyc !== m_done_cyc(0, -1, gd, 0) || o_rdata !== exp_rd)
            $display("FAIL store_done: got cyc=%0d rdata=%h want cyc=%0d rdata=%h", o_done_cyc, o_rdata, m_done_cyc(0, -1, gd, 0), exp_rd);
         else n_pass++;
      end
   endtask

   task automatic test_errors();
      bit          lds[4] = '{1, 0, 1, 1};
      bit          sts[4] = '{0, 1, 0, 1};
      logic [2:0]  f3s[4] = '{3'b010, 3'b001, 3'b011, 3'b010};
      logic [31:0] as[4]  = '{32'h102, 32'h203, 32'h100, 32'h100};
      int ec;
      for (int i = 0; i < 4; i++) begin
         run_access(lds[i], sts[i], f3s[i], as[i], 32'hA5A5_A5A5, 32'h1111_1111, 0, 0);
         ec = m_cause(lds[i], sts[i], f3s[i], as[i]);
         n_total++;
         if (o_done_cyc !== 1 || o_err !== 1'b1 || o_cause !== 2'(ec))
            $display("FAIL err_vec%0d: got cyc=%0d err=%0b cause=%0d want cyc=1 err=1 cause=%0d", i, o_done_cyc, o_err, o_cause, ec);
         else n_pass++;
         n_total++;
         if (o_req_seen || o_stall_cnt !== 1 || o_rdata !== exp_rd)
            $display("FAIL err_noreq%0d: got req=%0b stall_cyc=%0d rdata=%h want req=0 stall_cyc=1 rdata=%h",
                     i, o_req_seen, o_stall_cnt, o_rdata, exp_rd);
         else n_pass++;
      end
   endtask

   task automatic test_no_access();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         mem_valid = (i >= 3); mem_load = (i < 3); mem_store = 1'b0;
         mem_funct3 = 3'b010; mem_addr = 32'h40;
         @(negedge clk);
         n_total++;
         if ({lsu_stall, dmem_req, lsu_done} !== 3'b000)
            $display("FAIL no_access%0d: got stall=%0b req=%0b done=%0b want 0 0 0", i, lsu_stall, dmem_req, lsu_done);
         else n_pass++;
      end
      idle_cycles(1);
   endtask

   task automatic test_timeout();
      run_access(0, 1, 3'b010, 32'h300, 32'hCAFE_0001, 32'h0, 1000, 0);
      n_total++;
      if (o_done_cyc !== TO + 1 || o_err !== 1'b1 || o_cause !== 2'b11)
         $display("FAIL timeout_store: got cyc=%0d err=%0b cause=%0d want cyc=%0d err=1 cause=3", o_done_cyc, o_err, o_cause, TO + 1);
      else n_pass++;
      n_total++;
      if (o_req_cnt !== TO || o_unstable || o_stall_cnt !== TO + 1)
         $display("FAIL timeout_req: got req_cyc=%0d unstable=%0b stall_cyc=%0d want req_cyc=%0d unstable=0 stall_cyc=%0d",
                  o_req_cnt, o_unstable, o_stall_cnt, TO, TO + 1);
      else n_pass++;
      run_access(1, 0, 3'b010, 32'h304, 32'h0, 32'h7777_7777, 2, 1000);
      n_total++;
      if (o_done_cyc !== TO + 1 || o_err !== 1'b1 || o_cause !== 2'b11 || o_rdata !== exp_rd)
         $display("FAIL timeout_wait: got cyc=%0d err=%0b cause=%0d rdata=%h want cyc=%0d err=1 cause=3 rdata=%h",
                  o_done_cyc, o_err, o_cause, o_rdata, TO + 1, exp_rd);
      else n_pass++;
      idle_cycles(1);
      @(negedge clk);
      n_total++;
      if (lsu_stall !== 1'b0 || dmem_req !== 1'b0)
         $display("FAIL timeout_release: got stall=%0b req=%0b want 0 0", lsu_stall, dmem_req);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a, wd, rd;
      int gd, rdl, ec, e_cyc;
      for (int i = 0; i < 30; i++) begin
         ld = $urandom_range(0, 1);
         st = ($urandom_range(0, 7) == 0) ? 1'b1 : !ld;
         f3 = 3'($urandom_range(0, 7));
         a = $urandom; wd = $urandom; rd = $urandom;
         gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
         run_access(ld, st, f3, a, wd, rd, gd, rdl);
         ec = m_cause(ld, st, f3, a);
         e_cyc = m_done_cyc(ld, ec, gd, rdl);
         if (ec < 0 && ld) exp_rd = m_load(f3, a, rd);
         n_total++;
         if (o_done_cyc !== e_cyc || o_err !== (ec >= 0) || (ec >= 0 && o_cause !== 2'(ec)))
            $display("FAIL b2b_status%0d: got cyc=%0d err=%0b cause=%0d want cyc=%0d err=%0b cause=%0d",
                     i, o_done_cyc, o_err, o_cause, e_cyc, ec >= 0, ec);
         else n_pass++;
         n_total++;
         if (o_rdata !== exp_rd) $display("FAIL b2b_rdata%0d: got %h want %h", i, o_rdata, exp_rd);
         else n_pass++;
      end
      idle_cycles(1);
   endtask

   task automatic test_reset_mid_wait();
      run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h1357_2468, 0, 1);
      exp_rd = 32'h1357_2468;
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_load = 1'b1; mem_store = 1'b0; mem_funct3 = 3'b010; mem_addr = 32'h304;
      @(posedge clk); #1;
      dmem_gnt = dmem_req;
      @(posedge clk); #1;
      dmem_gnt = 1'b0; rst_n = 1'b0; mem_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      exp_rd = 32'b0;
      @(negedge clk);
      n_total++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, lsu_stall, lsu_done, lsu_err, lsu_err_cause, lsu_rdata} !== 107'b0)
         $display("FAIL rst_mid_outputs: got req=%0b addr=%h be=%b done=%0b rdata=%h want all 0",
                  dmem_req, dmem_addr, dmem_be, lsu_done, lsu_rdata);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         dmem_rvalid = 1'b0;
         @(negedge clk);
         n_total++;
         if (lsu_done !== 1'b0 || lsu_rdata !== exp_rd)
            $display("FAIL rst_late_rvalid%0d: got done=%0b rdata=%h want done=0 rdata=%h", i, lsu_done, lsu_rdata, exp_rd);
         else n_pass++;
      end
      run_access(1, 0, 3'b001, 32'h402, 32'h0, 32'h8001_0000, 0, 1);
      exp_rd = 32'hFFFF_8001;
      n_total++;
      if (o_done_cyc !== 3 || o_rdata !== exp_rd)
         $display("FAIL rst_resume: got cyc=%0d rdata=%h want cyc=3 rdata=%h", o_done_cyc, o_rdata, exp_rd);
      else n_pass++;
      idle_cycles(1);
   endtask

   initial begin
      test_reset();
      test_lw_basic();
      test_load_ext();
      test_store();
      test_errors();
      test_no_access();
      test_timeout();
      test_back_to_back();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
